// File: rtl/sdram_frame_writer_pkg.sv
// -----------------------------------------------------------------------------
// sdram_frame_pkg
// Definitions shared by the frame writer and the display read path. Both sides
// must agree on how a pixel word maps to an SDRAM address, so the field widths
// and the address-packing function live here.
//   FRAME_W / LINE_W / WORD_W : address field widths (6 / 10 / 9 bits)
//   ADDR_W                    : full word address width (25 bits)
//   WORDS_PER_LINE            : 16-bit words per scan line (1024 pixels)
//   writerState_t             : frame writer FSM encoding
//   frameAddr()               : {frame, line, word} address concatenation
// -----------------------------------------------------------------------------
package sdram_frame_pkg;

    localparam int FRAME_W        = 6;
    localparam int LINE_W         = 10;
    localparam int WORD_W         = 9;
    localparam int ADDR_W         = FRAME_W + LINE_W + WORD_W;
    localparam int WORDS_PER_LINE = 512;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_HI = 3'd1,
        GET_LO = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } writerState_t;

    // Fields are concatenated, never added, so a full line counter can never
    // carry into the frame slot.
    function automatic logic [ADDR_W-1:0] frameAddr(
        input logic [FRAME_W-1:0] frameId,
        input logic [LINE_W-1:0]  line,
        input logic [WORD_W-1:0]  word
    );
        return {frameId, line, word};
    endfunction

endpackage

// File: rtl/sdram_frame_writer_if.sv
// -----------------------------------------------------------------------------
// sdram_frame_writer_if
// Bundles the two data-path connections of the frame writer:
//   byte stream  : iBYTE, iBYTE_VALID (from source), oBYTE_READY (to source)
//   write port   : oWR_EN, oWR_ADDR, oWR_DATA (to SDRAM), iWAIT_REQUEST (back)
// Modport master is the frame writer; modport slave is the environment that
// supplies bytes and owns the SDRAM write port.
// -----------------------------------------------------------------------------
interface sdram_frame_writer_if;
    import sdram_frame_pkg::*;

    logic [7:0]        iBYTE;
    logic              iBYTE_VALID;
    logic              oBYTE_READY;
    logic              oWR_EN;
    logic [ADDR_W-1:0] oWR_ADDR;
    logic [15:0]       oWR_DATA;
    logic              iWAIT_REQUEST;

    modport master (
        input  iBYTE, iBYTE_VALID, iWAIT_REQUEST,
        output oBYTE_READY, oWR_EN, oWR_ADDR, oWR_DATA
    );

    modport slave (
        output iBYTE, iBYTE_VALID, iWAIT_REQUEST,
        input  oBYTE_READY, oWR_EN, oWR_ADDR, oWR_DATA
    );

endinterface

// File: rtl/sdram_frame_writer_byte_pair_packer.sv
// -----------------------------------------------------------------------------
// byte_pair_packer
// Packs two consecutive stream bytes into one 16-bit word, first byte in the
// upper half. The owning FSM says which half is being collected; the packer
// reports each byte handshake and holds the finished word until it is taken.
//   iCLK, iRST  : clock, synchronous active-high reset
//   captureHi   : collecting the first (upper) byte
//   captureLo   : collecting the second (lower) byte
//   byteData    : stream byte
//   byteValid   : stream byte valid
//   wordTaken   : the finished word has been consumed
//   hiTaken     : upper byte handshake this cycle
//   loTaken     : lower byte handshake this cycle
//   word        : packed word {first, second}
//   wordValid   : packed word complete and not yet taken
// -----------------------------------------------------------------------------
module byte_pair_packer (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        captureHi,
    input  logic        captureLo,
    input  logic [7:0]  byteData,
    input  logic        byteValid,
    input  logic        wordTaken,
    output logic        hiTaken,
    output logic        loTaken,
    output logic [15:0] word,
    output logic        wordValid
);

    assign hiTaken = captureHi && byteValid;
    assign loTaken = captureLo && byteValid;

    // Word halves are pure data and are overwritten before every use, so they
    // carry no reset; only the completion flag does.
    always_ff @(posedge iCLK) begin
        if (hiTaken) begin
            word[15:8] <= byteData;
        end
        if (loTaken) begin
            word[7:0] <= byteData;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wordValid <= 1'b0;
        end else if (loTaken) begin
            wordValid <= 1'b1;
        end else if (wordTaken) begin
            wordValid <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_frame_writer.sv
// -----------------------------------------------------------------------------
// sdram_frame_writer
// Writes one frame of 8-bit pixels from a byte stream into the SDRAM frame
// store as 16-bit single-word Avalon-style writes, filling the same address
// map the display read path scans out.
//   iCLK       : system clock
//   iRST       : synchronous active-high reset
//   iSTART     : frame request, honoured only when idle
//   iFRAME_ID  : frame slot, latched on an accepted start
//   oBUSY      : high from accepted start through the DONE cycle
//   oDONE      : one-cycle pulse after the last write is accepted
//   bus        : byte stream in and SDRAM write port out (master side)
// All outputs are decoded from registered state, so neither iWAIT_REQUEST nor
// iBYTE_VALID reaches an output combinationally.
// -----------------------------------------------------------------------------
module sdram_frame_writer
    import sdram_frame_pkg::*;
#(
    parameter int LINES          = 768,
    parameter int WORDS_PER_LINE = 512
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iSTART,
    input  logic [FRAME_W-1:0] iFRAME_ID,
    output logic               oBUSY,
    output logic               oDONE,
    sdram_frame_writer_if.master bus
);

    writerState_t        state;
    writerState_t        nextState;
    logic [FRAME_W-1:0]  frameId;
    logic [LINE_W-1:0]   lineCnt;
    logic [WORD_W-1:0]   wordCnt;

    logic                startTaken;
    logic                wrAccept;
    logic                lineEnd;
    logic                frameEnd;
    logic                hiTaken;
    logic                loTaken;
    logic [15:0]         packedWord;
    logic                wordValid;

    assign startTaken = (state == IDLE) && iSTART;
    assign wrAccept   = (state == WRITE) && !bus.iWAIT_REQUEST;
    assign lineEnd    = (wordCnt == WORD_W'(WORDS_PER_LINE - 1));
    assign frameEnd   = lineEnd && (lineCnt == LINE_W'(LINES - 1));

    byte_pair_packer packer (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .captureHi (state == GET_HI),
        .captureLo (state == GET_LO),
        .byteData  (bus.iBYTE),
        .byteValid (bus.iBYTE_VALID),
        .wordTaken (wrAccept),
        .hiTaken   (hiTaken),
        .loTaken   (loTaken),
        .word      (packedWord),
        .wordValid (wordValid)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (startTaken) nextState = GET_HI;
            GET_HI:  if (hiTaken)    nextState = GET_LO;
            GET_LO:  if (loTaken)    nextState = WRITE;
            WRITE:   if (wrAccept)   nextState = frameEnd ? DONE : GET_HI;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Word counter wraps 511 -> 0 on its own; the line counter only steps on
    // that wrap. Reaching LINES on the final word is harmless because the
    // next start clears both.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            frameId <= '0;
            lineCnt <= '0;
            wordCnt <= '0;
        end else if (startTaken) begin
            frameId <= iFRAME_ID;
            lineCnt <= '0;
            wordCnt <= '0;
        end else if (wrAccept) begin
            wordCnt <= wordCnt + 1'b1;
            if (lineEnd) begin
                lineCnt <= lineCnt + 1'b1;
            end
        end
    end

    // Address and data are only driven in WRITE; they stay stable through a
    // stall because counters and the packed word change only on acceptance.
    always_comb begin
        oBUSY           = (state != IDLE);
        oDONE           = (state == DONE);
        bus.oBYTE_READY = (state == GET_HI) || (state == GET_LO);
        bus.oWR_EN      = (state == WRITE) && wordValid;
        bus.oWR_ADDR    = '0;
        bus.oWR_DATA    = '0;
        if (state == WRITE) begin
            bus.oWR_ADDR = frameAddr(frameId, lineCnt, wordCnt);
            bus.oWR_DATA = packedWord;
        end
    end

endmodule

// File: tb/tb_sdram_frame_writer.sv
`timescale 1ns/1ps
module tb_sdram_frame_writer;
    import sdram_frame_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0;
    logic       start1;
    logic [5:0] frameIdIn;
    logic       busy0, done0, busy1, done1;
    logic [7:0] srcByte;
    logic       srcValid;
    logic       waitReq;

    always #5 clk = ~clk;

    sdram_frame_writer_if bus0 ();
    sdram_frame_writer_if bus1 ();

    assign bus0.iBYTE         = srcByte;
    assign bus0.iBYTE_VALID   = srcValid;
    assign bus0.iWAIT_REQUEST = waitReq;
    assign bus1.iBYTE         = srcByte;
    assign bus1.iBYTE_VALID   = srcValid;
    assign bus1.iWAIT_REQUEST = waitReq;

    sdram_frame_writer #(.LINES(2)) dut0 (
        .iCLK      (clk),
        .iRST      (rst),
        .iSTART    (start0),
        .iFRAME_ID (frameIdIn),
        .oBUSY     (busy0),
        .oDONE     (done0),
        .bus       (bus0)
    );

    sdram_frame_writer #(.LINES(1)) dut1 (
        .iCLK      (clk),
        .iRST      (rst),
        .iSTART    (start1),
        .iFRAME_ID (frameIdIn),
        .oBUSY     (busy1),
        .oDONE     (done1),
        .bus       (bus1)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Scoreboard entries: {address[24:0], data[15:0]}
    logic [40:0] expQ[$];

    int          sel;
    int          writes, dones, doneCycle, lastWrC, gapMin, gapMax;
    int          heldCycles, addrChanges, overlap;
    logic [24:0] firstAddr, addr511, lastAddr;
    logic [15:0] firstData;
    bit          byteFire;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sampleDut(output logic wr, output logic [24:0] ad, output logic [15:0] dt,
                             output logic rdy, output logic bsy, output logic dn);
        if (sel == 0) begin
            wr = bus0.oWR_EN; ad = bus0.oWR_ADDR; dt = bus0.oWR_DATA;
            rdy = bus0.oBYTE_READY; bsy = busy0; dn = done0;
        end else begin
            wr = bus1.oWR_EN; ad = bus1.oWR_ADDR; dt = bus1.oWR_DATA;
            rdy = bus1.oBYTE_READY; bsy = busy1; dn = done1;
        end
    endtask

    // Drives one frame into the selected writer and scores every write.
    // stallAt / midStartAt / abortAt select the write index for the special
    // event; a negative value disables it.
    task automatic runFrame(input int which, input logic [5:0] id, input bit randValid,
                            input int stallAt, input int midStartAt, input int abortAt,
                            input int budget);
        logic        wr, rdy, bsy, dn;
        logic [24:0] ad, heldAddr, ea;
        logic [15:0] dt, heldData;
        logic [40:0] e;
        logic [7:0]  hiByte;
        bit          haveHi, doneSeen, midDone, aborted;
        int          post, stallLeft, mLine, mWord;
        sel = which;
        writes = 0; dones = 0; doneCycle = -1; lastWrC = 0; gapMin = 1000000; gapMax = 0;
        heldCycles = 0; addrChanges = 0; overlap = 0;
        firstAddr = '0; addr511 = '0; lastAddr = '0; firstData = '0;
        byteFire = 0; haveHi = 0; doneSeen = 0; midDone = 0; aborted = 0;
        post = 0; stallLeft = 4; mLine = 0; mWord = 0; hiByte = '0;
        heldAddr = '0; heldData = '0;
        expQ.delete();
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (byteFire) srcByte++;
            start0 = 1'b0;
            start1 = 1'b0;
            if (c == 0) begin
                if (which == 0) start0 = 1'b1; else start1 = 1'b1;
                frameIdIn = id;
            end
            srcValid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
            sampleDut(wr, ad, dt, rdy, bsy, dn);
            waitReq = 1'b0;
            if (stallAt >= 0 && wr && writes == stallAt && stallLeft > 0) begin
                waitReq = 1'b1;
                stallLeft--;
            end
            if (midStartAt >= 0 && !midDone && wr && writes == midStartAt) begin
                if (which == 0) start0 = 1'b1; else start1 = 1'b1;
                frameIdIn = id ^ 6'h2A;
                midDone = 1;
            end
            if (abortAt >= 0 && wr && writes == abortAt) begin
                waitReq = 1'b1;
                rst = 1'b1;
                aborted = 1;
            end
            @(negedge clk);
            if (aborted) break;
            sampleDut(wr, ad, dt, rdy, bsy, dn);
            byteFire = srcValid && rdy;
            if (byteFire) begin
                if (!haveHi) begin
                    hiByte = srcByte;
                    haveHi = 1;
                end else begin
                    ea = (25'(id) << 19) | 25'(mLine << 9) | 25'(mWord);
                    expQ.push_back({ea, hiByte, srcByte});
                    haveHi = 0;
                    mWord++;
                    if (mWord == 512) begin
                        mWord = 0;
                        mLine++;
                    end
                end
            end
            if (wr && rdy) overlap++;
            if (stallAt >= 0 && wr && writes == stallAt) begin
                if (heldCycles == 0) begin
                    heldAddr = ad;
                    heldData = dt;
                end else if (ad !== heldAddr || dt !== heldData) begin
                    addrChanges++;
                end
                heldCycles++;
            end
            if (wr && !waitReq) begin
                if (expQ.size() == 0) begin
                    checkVal("sb_underflow", 32'(writes), 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkVal("wr_addr", 32'(ad), 32'(e[40:16]));
                    checkVal("wr_data", 32'(dt), 32'(e[15:0]));
                end
                if (writes == 0) begin
                    firstAddr = ad;
                    firstData = dt;
                end else begin
                    if (c - lastWrC < gapMin) gapMin = c - lastWrC;
                    if (c - lastWrC > gapMax) gapMax = c - lastWrC;
                end
                if (writes == 511) addr511 = ad;
                lastAddr = ad;
                lastWrC = c;
                writes++;
            end
            if (dn) begin
                if (!doneSeen) doneCycle = c;
                doneSeen = 1;
                dones++;
            end
            if (doneSeen) begin
                post++;
                if (post > 3) break;
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        if (abortAt < 0) begin
            checkVal("frame_completed", 32'(doneSeen), 32'd1);
            checkVal("busy_after_frame", 32'(bsy), 32'd0);
            checkVal("sb_drained", 32'(expQ.size()), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; frameIdIn = '0;
        srcByte = '0; srcValid = 1'b0; waitReq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_busy",  32'(busy0), 32'd0);
        checkVal("rst_done",  32'(done0), 32'd0);
        checkVal("rst_ready", 32'(bus0.oBYTE_READY), 32'd0);
        checkVal("rst_wren",  32'(bus0.oWR_EN), 32'd0);
        checkVal("rst_addr",  32'(bus0.oWR_ADDR), 32'd0);
        checkVal("rst_data",  32'(bus0.oWR_DATA), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Continuous stream, no stall, two lines
        srcByte = '0;
        runFrame(0, 6'd5, 0, -1, -1, -1, 5000);
        checkVal("A_writes",     32'(writes), 32'd1024);
        checkVal("A_dones",      32'(dones), 32'd1);
        checkVal("A_first_addr", 32'(firstAddr), 32'h0280000);
        checkVal("A_first_data", 32'(firstData), 32'h0001);
        checkVal("A_addr_511",   32'(addr511), 32'h02801FF);
        checkVal("A_last_addr",  32'(lastAddr), 32'h02803FF);
        checkVal("A_done_cycle", 32'(doneCycle), 32'd3073);
        checkVal("A_gap_min",    32'(gapMin), 32'd3);
        checkVal("A_gap_max",    32'(gapMax), 32'd3);

        // Four wait-request cycles on word 5
        srcByte = '0;
        runFrame(0, 6'd7, 0, 5, -1, -1, 6000);
        checkVal("B_writes",      32'(writes), 32'd1024);
        checkVal("B_dones",       32'(dones), 32'd1);
        checkVal("B_held_cycles", 32'(heldCycles), 32'd5);
        checkVal("B_held_stable", 32'(addrChanges), 32'd0);
        checkVal("B_no_byte",     32'(overlap), 32'd0);
        checkVal("B_done_cycle",  32'(doneCycle), 32'd3077);

        // Randomly gapped byte stream
        runFrame(0, 6'd3, 1, -1, -1, -1, 20000);
        checkVal("C_writes",  32'(writes), 32'd1024);
        checkVal("C_dones",   32'(dones), 32'd1);
        checkVal("C_no_byte", 32'(overlap), 32'd0);

        // Start with a different slot mid-frame is ignored
        runFrame(0, 6'd12, 0, -1, 100, -1, 5000);
        checkVal("D_writes",     32'(writes), 32'd1024);
        checkVal("D_dones",      32'(dones), 32'd1);
        checkVal("D_last_addr",  32'(lastAddr), 32'h06003FF);
        checkVal("D_done_cycle", 32'(doneCycle), 32'd3073);

        // Reset in WRITE while stalled, then a clean frame
        srcByte = '0;
        runFrame(0, 6'd9, 0, -1, -1, 3, 5000);
        @(negedge clk);
        checkVal("E_busy",  32'(busy0), 32'd0);
        checkVal("E_done",  32'(done0), 32'd0);
        checkVal("E_ready", 32'(bus0.oBYTE_READY), 32'd0);
        checkVal("E_wren",  32'(bus0.oWR_EN), 32'd0);
        checkVal("E_addr",  32'(bus0.oWR_ADDR), 32'd0);
        checkVal("E_data",  32'(bus0.oWR_DATA), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        waitReq = 1'b0;
        srcByte = '0;
        runFrame(0, 6'd9, 0, -1, -1, -1, 5000);
        checkVal("E_first_addr", 32'(firstAddr), 32'h0480000);
        checkVal("E_first_data", 32'(firstData), 32'h0001);
        checkVal("E_writes",     32'(writes), 32'd1024);
        checkVal("E_dones",      32'(dones), 32'd1);

        // Top frame slot, single line
        srcByte = '0;
        runFrame(1, 6'd63, 0, -1, -1, -1, 3000);
        checkVal("F_writes",     32'(writes), 32'd512);
        checkVal("F_first_addr", 32'(firstAddr), 32'h1F80000);
        checkVal("F_last_addr",  32'(lastAddr), 32'h1F801FF);
        checkVal("F_dones",      32'(dones), 32'd1);
        checkVal("F_done_cycle", 32'(doneCycle), 32'd1537);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sdram_frame_writer.md
# sdram_frame_writer

Writes one complete frame of 8-bit pixels from a byte stream into the SDRAM frame store. It packs byte pairs into 16-bit words and issues Avalon-style single-word writes with wait-request back-pressure. Each frame is placed at a selectable frame slot. It fills the same address map that the display read path scans out, so it sits between the host/upload byte FIFO and the SDRAM controller write port.

## Interface
Parameters:
- LINES, 768, number of lines per frame written (1..1024).
- WORDS_PER_LINE, 512, fixed 16-bit words per line (1024 pixels); not to be overridden.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- iCLK  in  1  system clock; all logic on posedge.
- iRST  in  1  synchronous active-high reset.
- iSTART  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- iFRAME_ID  in  6  frame slot, sampled on an accepted iSTART.
- oBUSY  out  1  high from accepted start until DONE inclusive.
- oDONE  out  1  one-cycle pulse after the last word write is accepted.
- iBYTE  in  8  pixel byte.
- iBYTE_VALID  in  1  iBYTE valid.
- oBYTE_READY  out  1  byte accepted at posedge when iBYTE_VALID && oBYTE_READY.
- oWR_EN  out  1  SDRAM write request.
- oWR_ADDR  out  25  {frame_id[5:0], line[9:0], word[8:0]}.
- oWR_DATA  out  16  {first byte, second byte}.
- iWAIT_REQUEST  in  1  SDRAM stall; a write is accepted at a posedge with oWR_EN && !iWAIT_REQUEST.

## Operation
- States: IDLE, GET_HI, GET_LO, WRITE, DONE.
- IDLE: on iSTART, latch iFRAME_ID, clear line/word counters, go to GET_HI.
- GET_HI: oBYTE_READY=1. On a byte handshake, load word[15:8] and go to GET_LO.
- GET_LO: oBYTE_READY=1. On a byte handshake, load word[7:0] and go to WRITE.
- WRITE: oBYTE_READY=0 and oWR_EN=1. oWR_ADDR and oWR_DATA are held stable while iWAIT_REQUEST=1.
  - When the write is accepted on the last word (line==LINES-1, word==511), go to DONE.
  - Otherwise increment the word counter and go to GET_HI. On word 511→0 wrap, increment line.
- DONE: oDONE=1 for one cycle, oBUSY=1, then IDLE.
- oBUSY=1 in every state except IDLE.
- iSTART outside IDLE is ignored.
- iFRAME_ID changes outside IDLE have no effect.
- iBYTE_VALID with ready low is not consumed. The source must hold the byte.
- Reset from any state:
  - Return to IDLE, discard any partial word/frame.
  - All outputs go to 0: oBUSY, oDONE, oBYTE_READY, oWR_EN, oWR_ADDR, oWR_DATA.
- Arithmetic rules:
  - The word counter is 9 bits and wraps naturally.
  - The line counter is 10 bits and compares against LINES-1.
  - No address carry into the frame field.

## Timing
- Accepted iSTART at edge N puts the block in GET_HI during cycle N+1 (oBYTE_READY=1).
- With continuous valid and no stall, the cycle is 3 cycles/word: GET_HI, GET_LO, WRITE.
- A full frame is 3·512·LINES cycles + start + DONE.
- oWR_EN asserts in the cycle after the second byte handshake.
- Each iWAIT_REQUEST cycle adds exactly one stall cycle.
- Outputs are registered/state-decoded. No combinational path from iWAIT_REQUEST or iBYTE_VALID to any output.
- oDONE is asserted in the cycle after the last write is accepted. IDLE follows, and a new iSTART is accepted in the cycle after DONE.

## Structure
- Shared package sdram_frame_pkg:
  - Address field widths: FRAME_W=6, LINE_W=10, WORD_W=9.
  - WORDS_PER_LINE=512.
  - State encoding.
  - Address-concatenation function (shared with the display read path).
- One sub-module: byte_pair_packer.
  - Handles GET_HI/GET_LO byte capture.
  - Outputs a 16-bit word plus a word_valid/word_taken handshake.
- The top level holds the FSM, the counters and the write port.

## Test plan
- LINES=2, bytes 0x00..0xFF repeating, valid always high, no stall:
  - 1024 writes.
  - First write addr {ID,0,0}, data 0x0001.
  - Word 511 of line 0 at addr {ID,0,511}.
  - Last write addr {ID,1,511}.
  - oDONE exactly once.
  - 3 cycles per word.
- iWAIT_REQUEST high 4 cycles on word 5 → oWR_EN/addr/data held 5 cycles, one write counted, no byte consumed meanwhile.
- iBYTE_VALID toggled randomly → packing unaffected (byte order preserved in data), write count still 512·LINES.
- iSTART pulsed mid-frame with a different iFRAME_ID → ignored; all addresses keep the latched ID; single oDONE.
- iRST asserted in WRITE with a pending stall → next cycle all outputs 0, state IDLE. A subsequent frame starts at word 0, line 0.
- iFRAME_ID=63, LINES=1 → addresses 0x1F80000..0x1F801FF, no wrap into other fields.
